// File: rtl/test_status_signaller.sv
// test_status_signaller - register-driven success/next_test pad signaller with pulse counter.
// Optional watchdog self-trigger is built when TEST_STATUS_WATCHDOG_EN is defined.
module test_status_signaller #(
  parameter int COUNT_WIDTH    = 16,
  parameter int DEFAULT_SETUP  = 4,
  parameter int DEFAULT_HIGH   = 8,
  parameter int DEFAULT_GAP    = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bus_sel,
  input  logic        bus_we,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ack,
  output logic        success_out,
  output logic        next_test_out,
  output logic [1:0]  io_oeb
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_HIGH, ST_GAP} state_e;

  localparam logic [23:0] CFG_RESET = {8'(DEFAULT_GAP), 8'(DEFAULT_HIGH), 8'(DEFAULT_SETUP)};

  state_e                 state_q, state_d;
  logic [7:0]             tmr_q, tmr_d;
  logic                   success_q, success_d;
  logic                   next_test_q, next_test_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   out_en_q, out_en_d;
  logic [23:0]            cfg_q, cfg_d;
  logic                   ack_q, ack_d;
  logic [31:0]            rdata_q, rdata_d;

  logic                   access;
  logic                   res_wr;
  logic                   start;
  logic                   start_pass;
  logic                   wd_en_bit;
  logic                   wd_fired_bit;
  logic [31:0]            status_w;
  logic                   unused_bits;

  assign unused_bits = ^bus_wdata[31:24];

  function automatic logic [7:0] eff(input logic [7:0] f);
    return (f == 8'd0) ? 8'd1 : f;
  endfunction

`ifdef TEST_STATUS_WATCHDOG_EN
  logic        wd_en_q, wd_en_d;
  logic        wd_fired_q, wd_fired_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  assign wd_en_bit    = wd_en_q;
  assign wd_fired_bit = wd_fired_q;
`else
  assign wd_en_bit    = 1'b0;
  assign wd_fired_bit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    success_d   = success_q;
    next_test_d = next_test_q;
    count_d     = count_q;
    out_en_d    = out_en_q;
    cfg_d       = cfg_q;
    ack_d       = 1'b0;
    rdata_d     = 32'd0;
    start       = 1'b0;
    start_pass  = 1'b0;
`ifdef TEST_STATUS_WATCHDOG_EN
    wd_en_d     = wd_en_q;
    wd_fired_d  = wd_fired_q;
    wd_cnt_d    = wd_cnt_q;
`endif

    status_w                      = 32'd0;
    status_w[0]                   = (state_q != ST_IDLE);
    status_w[1]                   = success_q;
    status_w[2]                   = wd_fired_bit;
    status_w[8 +: COUNT_WIDTH]    = count_q;

    // ack_q gates re-acceptance so a held bus_sel cannot complete twice
    access = bus_sel && !ack_q;
    res_wr = access && bus_we && (bus_addr == 2'd1);

    if (access && !res_wr) begin
      ack_d = 1'b1;
      if (bus_we) begin
        case (bus_addr)
          2'd0: begin
            out_en_d = bus_wdata[0];
`ifdef TEST_STATUS_WATCHDOG_EN
            wd_en_d    = bus_wdata[1];
            wd_fired_d = 1'b0;
`endif
          end
          2'd2:    cfg_d = bus_wdata[23:0];
          default: ;
        endcase
      end else begin
        case (bus_addr)
          2'd0:    rdata_d = {30'd0, wd_en_bit, out_en_q};
          2'd1:    rdata_d = {31'd0, success_q};
          2'd2:    rdata_d = {8'd0, cfg_q};
          default: rdata_d = status_w;
        endcase
      end
    end

    if (res_wr && (state_q == ST_IDLE)) begin
      ack_d      = 1'b1;
      start      = 1'b1;
      start_pass = bus_wdata[0];
    end

`ifdef TEST_STATUS_WATCHDOG_EN
    if (start) begin
      wd_cnt_d = 32'd0;
    end else if (!wd_en_q) begin
      wd_cnt_d = 32'd0;
    end else if (state_q == ST_IDLE) begin
      if (wd_cnt_q >= 32'(TIMEOUT_CYCLES - 1)) begin
        start      = 1'b1;
        start_pass = 1'b0;
        wd_en_d    = 1'b0;
        wd_fired_d = 1'b1;
        wd_cnt_d   = 32'd0;
      end else begin
        wd_cnt_d = wd_cnt_q + 32'd1;
      end
    end
`endif

    // SETUP loads the full value so the ack cycle itself is not counted as setup time
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_SETUP;
          success_d = start_pass;
          tmr_d     = eff(cfg_q[7:0]);
        end
      end
      ST_SETUP: begin
        if (tmr_q == 8'd0) begin
          state_d     = ST_HIGH;
          next_test_d = 1'b1;
          tmr_d       = eff(cfg_q[15:8]) - 8'd1;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_HIGH: begin
        if (tmr_q == 8'd0) begin
          state_d     = ST_GAP;
          next_test_d = 1'b0;
          count_d     = count_q + 1'b1;
          tmr_d       = eff(cfg_q[23:16]) - 8'd1;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      default: begin
        if (tmr_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tmr_q       <= 8'd0;
      success_q   <= 1'b0;
      next_test_q <= 1'b0;
      count_q     <= '0;
      out_en_q    <= 1'b0;
      cfg_q       <= CFG_RESET;
      ack_q       <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      success_q   <= success_d;
      next_test_q <= next_test_d;
      count_q     <= count_d;
      out_en_q    <= out_en_d;
      cfg_q       <= cfg_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef TEST_STATUS_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_en_q    <= 1'b0;
      wd_fired_q <= 1'b0;
      wd_cnt_q   <= 32'd0;
    end else begin
      wd_en_q    <= wd_en_d;
      wd_fired_q <= wd_fired_d;
      wd_cnt_q   <= wd_cnt_d;
    end
  end
`endif

  assign bus_ack       = ack_q;
  assign bus_rdata     = rdata_q;
  assign success_out   = success_q;
  assign next_test_out = next_test_q;
  assign io_oeb        = out_en_q ? 2'b00 : 2'b11;

endmodule

// File: tb/tb_test_status_signaller.sv
// tb_test_status_signaller - randomized directed bench with a timing-rule reference model.
module tb_test_status_signaller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_sel = 1'b0;
  logic        bus_we = 1'b0;
  logic [1:0]  bus_addr = 2'd0;
  logic [31:0] bus_wdata = 32'd0;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        success_out;
  logic        next_test_out;
  logic [1:0]  io_oeb;

  test_status_signaller #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .success_out(success_out), .next_test_out(next_test_out),
    .io_oeb(io_oeb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  // observed pad edges, recorded as the index of the clock edge that produced them
  int rise_q[$];
  int rsucc_q[$];
  int fall_q[$];
  logic prev_nt = 1'b0;
  always @(negedge clk) begin
    if (rst_n && next_test_out && !prev_nt) begin
      rise_q.push_back(cyc);
      rsucc_q.push_back(int'(success_out));
    end
    if (rst_n && !next_test_out && prev_nt) fall_q.push_back(cyc);
    prev_nt <= next_test_out;
  end

  // reference model: pulse schedule derived from the SETUP/HIGH/GAP rules
  int exp_rise[$];
  int exp_succ[$];
  int exp_fall[$];
  int ready = 0;
  int exp_count = 0;
  int m_s = 4, m_h = 8, m_g = 8;
  int last_pass = 0;

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff(input int f);
    return (f == 0) ? 1 : f;
  endfunction

  task automatic bus(input bit we, input logic [1:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output int issue, output int ackc);
    @(negedge clk);
    bus_sel = 1'b1; bus_we = we; bus_addr = addr; bus_wdata = wd;
    issue = cyc + 1;
    ackc = -1;
    rd = 32'd0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus_ack) begin
        ackc = cyc;
        rd = bus_rdata;
        break;
      end
    end
    bus_sel = 1'b0; bus_we = 1'b0;
    chk("ack_seen", 32'(ackc >= 0), 32'd1);
    @(negedge clk);
    chk("ack_one_cycle", 32'(bus_ack), 32'd0);
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
    logic [31:0] rd;
    int iss, ac;
    bus(1'b1, addr, wd, rd, iss, ac);
    if (addr == 2'd2) begin
      m_s = eff(int'(wd[7:0])); m_h = eff(int'(wd[15:8])); m_g = eff(int'(wd[23:16]));
    end
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    int iss, ac;
    bus(1'b0, addr, 32'd0, rd, iss, ac);
    chk(tag, rd, exp);
  endtask

  task automatic write_result(input int pass);
    logic [31:0] rd;
    int iss, ac, a, r;
    bus(1'b1, 2'd1, 32'(pass), rd, iss, ac);
    a = (iss > ready) ? iss : ready;
    chk("result_ack_cycle", 32'(ac), 32'(a));
    chk("success_after_ack", 32'(success_out), 32'(pass));
    r = a + m_s + 1;
    exp_rise.push_back(r);
    exp_succ.push_back(pass);
    exp_fall.push_back(r + m_h);
    ready = r + m_h + m_g + 1;
    exp_count++;
    last_pass = pass;
  endtask

  task automatic wait_idle();
    while (cyc < ready + 1) @(negedge clk);
  endtask

  task automatic check_pulses(input string tag);
    int n;
    chk({tag, "_rise_count"}, 32'(rise_q.size()), 32'(exp_rise.size()));
    chk({tag, "_fall_count"}, 32'(fall_q.size()), 32'(exp_fall.size()));
    n = (rise_q.size() < exp_rise.size()) ? rise_q.size() : exp_rise.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_rise_cycle"}, 32'(rise_q[i]), 32'(exp_rise[i]));
      chk({tag, "_success_at_rise"}, 32'(rsucc_q[i]), 32'(exp_succ[i]));
      if (i < fall_q.size()) chk({tag, "_fall_cycle"}, 32'(fall_q[i]), 32'(exp_fall[i]));
    end
    rise_q.delete(); rsucc_q.delete(); fall_q.delete();
    exp_rise.delete(); exp_succ.delete(); exp_fall.delete();
  endtask

  function automatic logic [31:0] exp_status();
    return (32'(exp_count % 65536) << 8) | (32'(last_pass) << 1);
  endfunction

  initial begin
    logic [31:0] cfgv;
    repeat (3) @(negedge clk);
    chk("rst_success", 32'(success_out), 32'd0);
    chk("rst_next_test", 32'(next_test_out), 32'd0);
    chk("rst_io_oeb", 32'(io_oeb), 32'd3);
    chk("rst_ack", 32'(bus_ack), 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    rst_n = 1'b1;

    rd_chk("rst_ctrl", 2'd0, 32'd0);
    rd_chk("rst_result", 2'd1, 32'd0);
    rd_chk("rst_cfg", 2'd2, 32'h00080804);
    rd_chk("rst_status", 2'd3, 32'd0);

    wr(2'd0, 32'd1);
    chk("oeb_enabled", 32'(io_oeb), 32'd0);
    wr(2'd2, 32'h00020302);
    write_result(1);
    wait_idle();
    check_pulses("single");
    rd_chk("single_status", 2'd3, exp_status());
    rd_chk("single_result", 2'd1, 32'd1);

    write_result(1);
    write_result(0);
    wait_idle();
    check_pulses("b2b");
    rd_chk("b2b_status", 2'd3, exp_status());
    rd_chk("b2b_result", 2'd1, 32'd0);

    wr(2'd2, 32'd0);
    write_result(1);
    wait_idle();
    check_pulses("min_cfg");
    rd_chk("min_cfg_readback", 2'd2, 32'd0);

    write_result(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_next_test", 32'(next_test_out), 32'd0);
    chk("midrst_success", 32'(success_out), 32'd0);
    chk("midrst_io_oeb", 32'(io_oeb), 32'd3);
    rst_n = 1'b1;
    rise_q.delete(); rsucc_q.delete(); fall_q.delete();
    exp_rise.delete(); exp_succ.delete(); exp_fall.delete();
    ready = 0; exp_count = 0; last_pass = 0; m_s = 4; m_h = 8; m_g = 8;
    repeat (30) @(negedge clk);
    chk("midrst_no_pulse", 32'(rise_q.size()), 32'd0);
    rd_chk("midrst_status", 2'd3, 32'd0);
    rd_chk("midrst_cfg", 2'd2, 32'h00080804);

    for (int i = 0; i < 18; i++) begin
      if (i == 0 || i == 9) begin
        wait_idle();
        cfgv = {8'd0, 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5)), 8'($urandom_range(0, 5))};
        wr(2'd2, cfgv);
      end
      write_result((i == 17) ? 1 : int'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 12)) @(negedge clk);
    end
    wait_idle();
    chk("rand_rise_total", 32'(rise_q.size()), 32'd18);
    check_pulses("rand");
    rd_chk("rand_status", 2'd3, exp_status());
    chk("rand_oeb_disabled", 32'(io_oeb), 32'd3);

    wr(2'd0, 32'd3);
`ifdef TEST_STATUS_WATCHDOG_EN
    for (int i = 0; i < 400 && rise_q.size() == 0; i++) @(negedge clk);
    chk("wd_pulse_seen", 32'(rise_q.size()), 32'd1);
    if (rsucc_q.size() > 0) chk("wd_pulse_pass", 32'(rsucc_q[0]), 32'd0);
    repeat (60) @(negedge clk);
    exp_count++;
    last_pass = 0;
    rd_chk("wd_status", 2'd3, exp_status() | 32'd4);
    rd_chk("wd_ctrl", 2'd0, 32'd1);
`else
    repeat (150) @(negedge clk);
    chk("nowd_no_pulse", 32'(rise_q.size()), 32'd0);
    rd_chk("nowd_ctrl", 2'd0, 32'd1);
    rd_chk("nowd_status", 2'd3, exp_status());
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
